// File: rtl/uart_comm.sv
// uart_comm: turns a stream of UART bytes into 24-bit commands (big-endian,
// three bytes per command) and sends single response bytes back out.
// RX and TX FSMs run independently.
//
// Handshakes:
//   rx_rdy/clr_rx_rdy : a byte is taken in the cycle where rx_rdy=1 and cmd_rdy=0;
//                       clr_rx_rdy is high in that same cycle and the byte is
//                       registered on the closing edge.
//   cmd_rdy/clr_cmd_rdy: cmd_rdy rises on the edge that stores the third byte
//                       and falls on the edge after clr_cmd_rdy (set wins).
//   send_resp/trmt    : in TX_IDLE send_resp loads tx_data; trmt pulses the
//                       cycle after, together with the loaded byte.
//   tx_done/resp_sent : in TX_BUSY tx_done ends the transfer; resp_sent pulses
//                       the cycle after.
//
// Optional feature: define UART_COMM_TIMEOUT_EN to add the inter-byte timeout
// (TIMEOUT_CYCLES idle cycles in B1/B2 drop the partial command, pulse frm_err).
module uart_comm #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [7:0]  tx_data,
   output logic        trmt,
   input  logic        tx_done,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp_data,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        frm_err,
   output logic [1:0]  rx_state_dbg,
   output logic        tx_state_dbg
);

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2
   } rx_state_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_t;

   rx_state_t rx_state;
   rx_state_t rx_next;
   tx_state_t tx_state;
   tx_state_t tx_next;

   logic accept;
   logic timeout;
   logic tx_load;
   logic tx_fin;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("uart_comm: TIMEOUT_CYCLES must be at least 1");
   end

   // A byte is taken whenever one is offered and no finished command is waiting.
   // rst_n keeps the acknowledge quiet while reset is held.
   assign accept = rst_n & rx_rdy & ~cmd_rdy;

   assign rx_state_dbg = rx_state;
   assign tx_state_dbg = tx_state;

`ifdef UART_COMM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] to_cnt;
   logic             to_armed;

   // Counting only makes sense mid-command with nothing arriving.
   assign to_armed = (rx_state != B0) && !cmd_rdy && !accept;
   assign timeout  = to_armed && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Idle-gap counter; restarts on every byte and outside B1/B2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (!to_armed || timeout) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // One-cycle framing error pulse when a partial command is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_err <= 1'b0;
      end else begin
         frm_err <= timeout;
      end
   end
`else
   assign timeout = 1'b0;
   assign frm_err = 1'b0;
`endif

   // RX state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= B0;
      end else begin
         rx_state <= rx_next;
      end
   end

   // RX next state: advance one slot per accepted byte, fall back to B0 on timeout.
   always_comb begin
      rx_next    = rx_state;
      clr_rx_rdy = 1'b0;
      if (accept) begin
         clr_rx_rdy = 1'b1;
         case (rx_state)
            B0:      rx_next = B1;
            B1:      rx_next = B2;
            default: rx_next = B0;
         endcase
      end else if (timeout) begin
         rx_next = B0;
      end
   end

   // Command assembly and ready flag; a new third byte beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd     <= 24'h000000;
         cmd_rdy <= 1'b0;
      end else begin
         if (accept) begin
            case (rx_state)
               B0:      cmd[23:16] <= rx_data;
               B1:      cmd[15:8]  <= rx_data;
               default: cmd[7:0]   <= rx_data;
            endcase
         end
         if (accept && (rx_state == B2)) begin
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   // TX state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
      end else begin
         tx_state <= tx_next;
      end
   end

   // TX next state: one response in flight at a time; stray requests/dones ignored.
   always_comb begin
      tx_next = tx_state;
      tx_load = 1'b0;
      tx_fin  = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (send_resp) begin
               tx_load = 1'b1;
               tx_next = TX_BUSY;
            end
         end
         default: begin
            if (tx_done) begin
               tx_fin  = 1'b1;
               tx_next = TX_IDLE;
            end
         end
      endcase
   end

   // TX datapath: capture the response byte and emit the start/finish pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data   <= 8'h00;
         trmt      <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         if (tx_load) begin
            tx_data <= resp_data;
         end
         trmt      <= tx_load;
         resp_sent <= tx_fin;
      end
   end

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm: directed steps followed by randomized command and
// response traffic, compared against byte-grouping and response-queue models.
module tb_uart_comm;

   localparam int unsigned TO    = 16;
   localparam int          NCMD  = 20;
   localparam int          NRESP = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_rdy = 1'b0;
   logic        clr_rx_rdy;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done = 1'b0;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp_data = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        frm_err;
   logic [1:0]  rx_state_dbg;
   logic        tx_state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0] exp_q[$];
   logic [7:0]  exp_tx[$];

   // Clock generator.
   always #5 clk = ~clk;

   uart_comm #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_rdy       (rx_rdy),
      .clr_rx_rdy   (clr_rx_rdy),
      .tx_data      (tx_data),
      .trmt         (trmt),
      .tx_done      (tx_done),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .resp_data    (resp_data),
      .send_resp    (send_resp),
      .resp_sent    (resp_sent),
      .frm_err      (frm_err),
      .rx_state_dbg (rx_state_dbg),
      .tx_state_dbg (tx_state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic look();
      #2;
   endtask

   // Offer one byte and hold it until acknowledged (bounded), then withdraw.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited  = 0;
      rx_data = b;
      rx_rdy  = 1'b1;
      look();
      while (clr_rx_rdy !== 1'b1 && waited < 50) begin
         cyc();
         look();
         waited++;
      end
      chk("rx_ack_wait", clr_rx_rdy, 1);
      cyc();
      rx_rdy = 1'b0;
   endtask

   task automatic clear_cmd();
      clr_cmd_rdy = 1'b1;
      cyc();
      clr_cmd_rdy = 1'b0;
      look();
      chk("cmd_rdy_cleared", cmd_rdy, 0);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          frm_cnt;
      int          hold;
      int          gap;
      int          dly;
      logic [7:0]  b [3];
      logic [7:0]  r1;
      logic [7:0]  r2;
      logic [23:0] e;

      // Reset with activity on the inputs: everything must stay quiet.
      rst_n     = 1'b0;
      rx_rdy    = 1'b1;
      rx_data   = 8'h55;
      send_resp = 1'b1;
      resp_data = 8'h66;
      repeat (3) cyc();
      look();
      chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
      chk("rst_trmt", trmt, 0);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_resp_sent", resp_sent, 0);
      chk("rst_frm_err", frm_err, 0);
      chk("rst_cmd", cmd, 24'h000000);
      chk("rst_tx_data", tx_data, 8'h00);
      rx_rdy    = 1'b0;
      send_resp = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();

      // Basic three-byte command.
      send_byte(8'h01);
      send_byte(8'h23);
      look();
      chk("two_bytes_not_ready", cmd_rdy, 0);
      send_byte(8'h45);
      look();
      chk("cmd_rdy_after_third", cmd_rdy, 1);
      chk("cmd_012345", cmd, 24'h012345);

      // Backpressure: fourth byte waits while cmd_rdy is set.
      rx_data = 8'hAA;
      rx_rdy  = 1'b1;
      look();
      for (int i = 0; i < 3; i++) begin
         chk("bp_no_ack", clr_rx_rdy, 0);
         chk("bp_cmd_hold", cmd, 24'h012345);
         cyc();
         look();
      end
      clr_cmd_rdy = 1'b1;
      look();
      chk("bp_no_ack_during_clear", clr_rx_rdy, 0);
      cyc();
      clr_cmd_rdy = 1'b0;
      look();
      chk("bp_cmd_rdy_low", cmd_rdy, 0);
      chk("bp_ack_after_clear", clr_rx_rdy, 1);
      cyc();
      rx_rdy = 1'b0;
      look();
      chk("bp_first_slot", cmd, 24'hAA2345);

      // Third byte together with clr_cmd_rdy: set wins.
      send_byte(8'hBB);
      rx_data     = 8'hCC;
      rx_rdy      = 1'b1;
      clr_cmd_rdy = 1'b1;
      look();
      chk("setwin_ack", clr_rx_rdy, 1);
      cyc();
      rx_rdy      = 1'b0;
      clr_cmd_rdy = 1'b0;
      look();
      chk("setwin_cmd_rdy", cmd_rdy, 1);
      chk("setwin_cmd", cmd, 24'hAABBCC);
      clear_cmd();

      // Response path: load, ignored second request, finish.
      resp_data = 8'hA5;
      send_resp = 1'b1;
      cyc();
      send_resp = 1'b0;
      look();
      chk("tx_trmt_pulse", trmt, 1);
      chk("tx_data_a5", tx_data, 8'hA5);
      cyc();
      look();
      chk("tx_trmt_single", trmt, 0);
      resp_data = 8'h5A;
      send_resp = 1'b1;
      cyc();
      send_resp = 1'b0;
      look();
      chk("tx_busy_no_trmt", trmt, 0);
      chk("tx_busy_data_hold", tx_data, 8'hA5);
      cyc();
      look();
      chk("tx_busy_no_trmt2", trmt, 0);
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      look();
      chk("tx_resp_sent", resp_sent, 1);
      cyc();
      look();
      chk("tx_resp_sent_single", resp_sent, 0);
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      look();
      chk("tx_done_idle_ignored", resp_sent, 0);

      // RX acceptance and TX start in the same cycle.
      rx_data   = 8'h10;
      rx_rdy    = 1'b1;
      resp_data = 8'h77;
      send_resp = 1'b1;
      look();
      chk("both_ack", clr_rx_rdy, 1);
      cyc();
      rx_rdy    = 1'b0;
      send_resp = 1'b0;
      look();
      chk("both_trmt", trmt, 1);
      chk("both_tx_data", tx_data, 8'h77);
      send_byte(8'h20);
      send_byte(8'h30);
      look();
      chk("both_cmd", cmd, 24'h102030);
      chk("both_cmd_rdy", cmd_rdy, 1);
      clear_cmd();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      look();
      chk("both_resp_sent", resp_sent, 1);
      cyc();

      // Long inter-byte gap.
      send_byte(8'h11);
      frm_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         look();
         if (frm_err === 1'b1) frm_cnt++;
      end
`ifdef UART_COMM_TIMEOUT_EN
      chk("gap_frm_err_pulses", frm_cnt, 1);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      look();
      chk("gap_cmd_after_timeout", cmd, 24'h223344);
      chk("gap_cmd_rdy", cmd_rdy, 1);
      clear_cmd();
`else
      chk("gap_no_frm_err", frm_cnt, 0);
      send_byte(8'h22);
      send_byte(8'h33);
      look();
      chk("gap_cmd_waits", cmd, 24'h112233);
      chk("gap_cmd_rdy", cmd_rdy, 1);
      clear_cmd();
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      look();
      chk("gap_next_cmd", cmd, 24'h445566);
      clear_cmd();
`endif

      // Reset in the middle of a command and of a transmission.
      send_byte(8'h01);
      send_byte(8'h02);
      resp_data = 8'h99;
      send_resp = 1'b1;
      cyc();
      send_resp = 1'b0;
      cyc();
      rst_n   = 1'b0;
      rx_data = 8'hEE;
      rx_rdy  = 1'b1;
      look();
      chk("mid_rst_clr_rx_rdy", clr_rx_rdy, 0);
      chk("mid_rst_cmd", cmd, 24'h000000);
      chk("mid_rst_cmd_rdy", cmd_rdy, 0);
      chk("mid_rst_tx_data", tx_data, 8'h00);
      chk("mid_rst_trmt", trmt, 0);
      chk("mid_rst_resp_sent", resp_sent, 0);
      chk("mid_rst_frm_err", frm_err, 0);
      cyc();
      cyc();
      rx_rdy = 1'b0;
      rst_n  = 1'b1;
      cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      look();
      chk("mid_rst_no_resp_sent", resp_sent, 0);
      send_byte(8'hDE);
      send_byte(8'hAD);
      look();
      chk("mid_rst_not_ready", cmd_rdy, 0);
      send_byte(8'h01);
      look();
      chk("mid_rst_cmd_dead01", cmd, 24'hDEAD01);
      chk("mid_rst_cmd_rdy_set", cmd_rdy, 1);
      clear_cmd();

      // Random commands: every three accepted bytes form one big-endian word.
      for (int c = 0; c < NCMD; c++) begin
         for (int k = 0; k < 3; k++) b[k] = 8'($urandom_range(0, 255));
         exp_q.push_back({b[0], b[1], b[2]});
         for (int k = 0; k < 3; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) cyc();
            send_byte(b[k]);
            look();
            if (k < 2) chk("rand_not_ready", cmd_rdy, 0);
         end
         e = exp_q.pop_front();
         chk("rand_cmd_rdy", cmd_rdy, 1);
         chk("rand_cmd", cmd, e);
         hold = $urandom_range(0, 4);
         for (int h = 0; h < hold; h++) begin
            cyc();
            look();
            chk("rand_cmd_held", cmd, e);
         end
         clear_cmd();
      end

      // Random responses: exactly the byte presented at the accepted request goes out.
      for (int i = 0; i < NRESP; i++) begin
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         exp_tx.push_back(r1);
         resp_data = r1;
         send_resp = 1'b1;
         cyc();
         send_resp = 1'b0;
         resp_data = r2;
         look();
         chk("rtx_trmt", trmt, 1);
         chk("rtx_data", tx_data, exp_tx[0]);
         dly = $urandom_range(1, 5);
         for (int k = 0; k < dly; k++) begin
            send_resp = 1'($urandom_range(0, 1));
            cyc();
            send_resp = 1'b0;
            look();
            chk("rtx_data_hold", tx_data, exp_tx[0]);
            chk("rtx_no_retrigger", trmt, 0);
            chk("rtx_not_done", resp_sent, 0);
         end
         tx_done = 1'b1;
         cyc();
         tx_done = 1'b0;
         look();
         chk("rtx_resp_sent", resp_sent, 1);
         void'(exp_tx.pop_front());
         cyc();
         look();
         chk("rtx_resp_sent_end", resp_sent, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_comm.md
UART_COMM -- requirements
Module: uart_comm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte gap limit in clk cycles (used only with UART_COMM_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_rdy  input  1  level; byte valid until cleared.
REQ-006 SHALL have port clr_rx_rdy  output  1  1-cycle pulse acknowledging rx byte.
REQ-007 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-008 SHALL have port trmt  output  1  1-cycle pulse starting transmission.
REQ-009 SHALL have port tx_done  input  1  1-cycle pulse, transmission finished.
REQ-010 SHALL have port cmd  output  24  assembled command to core.
REQ-011 SHALL have port cmd_rdy  output  1  level; cmd valid.
REQ-012 SHALL have port clr_cmd_rdy  input  1  core consumed cmd.
REQ-013 SHALL have port resp_data  input  8  response byte from core.
REQ-014 SHALL have port send_resp  input  1  core requests response send.
REQ-015 SHALL have port resp_sent  output  1  1-cycle pulse, response finished.
REQ-016 SHALL have port frm_err  output  1  1-cycle pulse, partial command discarded.

Function
REQ-017 RX FSM states SHALL be B0, B1, B2; byte order big-endian: first byte cmd[23:16], second cmd[15:8], third cmd[7:0].
REQ-018 A byte SHALL be accepted when rx_rdy=1 and cmd_rdy=0: byte registered into its cmd slice, clr_rx_rdy pulsed same cycle, FSM advances B0->B1->B2->B0.
REQ-019 While cmd_rdy=1, clr_rx_rdy SHALL stay 0 and rx_rdy bytes SHALL remain unaccepted (backpressure); no byte lost.
REQ-020 Accepting the third byte SHALL set cmd_rdy on the next rising edge (latency 1 cycle from acceptance edge); all 24 cmd bits valid simultaneously with cmd_rdy.
REQ-021 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; cmd SHALL hold its value until overwritten by a new first byte.
REQ-022 If third-byte set and clr_cmd_rdy occur in the same cycle, set SHALL win.
REQ-023 TX FSM states SHALL be TX_IDLE, TX_BUSY.
REQ-024 In TX_IDLE, send_resp=1 SHALL register resp_data into tx_data, pulse trmt one cycle, enter TX_BUSY.
REQ-025 In TX_BUSY, send_resp SHALL be ignored; tx_data SHALL remain stable.
REQ-026 In TX_BUSY, tx_done=1 SHALL pulse resp_sent one cycle and return to TX_IDLE; tx_done in TX_IDLE SHALL be ignored.
REQ-027 RX and TX FSMs SHALL operate independently; simultaneous rx acceptance and tx start SHALL both occur.
REQ-028 frm_err SHALL be 0 except as per REQ-033.

Reset
REQ-029 rst_n low SHALL force RX FSM to B0, TX FSM to TX_IDLE, cmd=24'h000000, tx_data=8'h00.
REQ-030 rst_n low SHALL force clr_rx_rdy, trmt, cmd_rdy, resp_sent, frm_err to 0, timeout counter to 0.
REQ-031 Reset mid-command SHALL discard partial bytes; mid-transmission SHALL drop pending resp_sent.

Configuration
REQ-032 Macro UART_COMM_TIMEOUT_EN SHALL compile in the inter-byte timeout.
REQ-033 With UART_COMM_TIMEOUT_EN: counter clears on each accepted byte, increments in B1/B2 while no byte accepted; reaching TIMEOUT_CYCLES SHALL return FSM to B0 and pulse frm_err one cycle; counter inactive in B0 or while cmd_rdy=1.
REQ-034 Without UART_COMM_TIMEOUT_EN: no counter logic, FSM waits indefinitely in B1/B2, frm_err tied 0.

Verification
REQ-035 Bytes 0x01,0x23,0x45 via rx_rdy -> three clr_rx_rdy pulses, cmd=24'h012345, cmd_rdy=1 one cycle after third acceptance.
REQ-036 cmd_rdy=1 with fourth byte 0xAA pending -> clr_rx_rdy stays 0; after clr_cmd_rdy, 0xAA accepted next cycle as cmd[23:16].
REQ-037 send_resp with resp_data=0xA5 -> tx_data=0xA5, trmt one pulse; second send_resp 0x5A in TX_BUSY ignored; tx_done -> resp_sent one pulse.
REQ-038 Third byte accepted in same cycle clr_cmd_rdy=1 -> cmd_rdy=1 next cycle.
REQ-039 With UART_COMM_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte 0x11 then 16-cycle gap -> frm_err pulse, next bytes 0x22,0x33,0x44 give cmd=24'h223344.
REQ-040 rst_n asserted after two bytes and during TX_BUSY -> all outputs 0, next three bytes 0xDE,0xAD,0x01 give cmd=24'hDEAD01, no resp_sent.
